spi_primary: RTL

SPI_PRIMARY -- requirements
Module: spi_primary

---
 rtl/spi_primary_pkg.sv | 28 ++
 rtl/spi_primary_tick_gen.sv | 28 ++
 rtl/spi_primary.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/spi_primary_pkg.sv
// Shared gsensor SPI definitions: FSM encoding, frame width and accelerometer register map.
// Pure declarations, no timing or flow control of its own.
package spi_primary_pkg;

  localparam int XFER_BITS = 16;
  localparam int BIT_CNT_W = 5;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_XFER  = 3'd2,
    ST_HOLD  = 3'd3,
    ST_GAP   = 3'd4
  } spi_state_e;

  localparam logic [5:0] REG_DEVID       = 6'h00;
  localparam logic [5:0] REG_POWER_CTL   = 6'h2D;
  localparam logic [5:0] REG_DATA_FORMAT = 6'h31;
  localparam logic [5:0] REG_DATAX0      = 6'h32;

  // Frame layout on the wire, MSB first: R/W, multi-byte bit (always 0), address, data.
  function automatic logic [XFER_BITS-1:0] make_frame(input logic       rw,
                                                      input logic [5:0] addr,
                                                      input logic [7:0] wdata);
    return {rw, 1'b0, addr, wdata};
  endfunction

endpackage

// File: rtl/spi_primary_tick_gen.sv
// Half-period timer: counts DIV-1 down to 0 and ticks for one cycle at 0, reloading without drift.
// clr holds the count at DIV-1 so the first tick after release lands exactly DIV cycles later.
module spi_tick_gen #(
  parameter int DIV = 25
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  output logic tick
);

  localparam logic [7:0] RELOAD = 8'(DIV - 1);

  logic [7:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= RELOAD;
    end else if (clr || (cnt == 8'd0)) begin
      cnt <= RELOAD;
    end else begin
      cnt <= cnt - 8'd1;
    end
  end

  assign tick = (cnt == 8'd0);

endmodule

// File: rtl/spi_primary.sv
// SPI mode 3 primary for the gsensor register bus: one 16-bit frame per accepted start.
// done pulses 34*CLK_DIV cycles after accept; start is ignored while busy, nothing is queued.
module spi_primary
  import spi_primary_pkg::*;
#(
  parameter int CLK_DIV = 25
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       rw,
  input  logic [5:0] addr,
  input  logic [7:0] wdata,
  output logic       busy,
  output logic       done,
  output logic [7:0] rdata,
  output logic       SPI_CSN,
  output logic       SPI_CLK,
  output logic       SPI_SDI,
  input  logic       SPI_SDO
);

  spi_state_e state;
  spi_state_e state_d;

  logic [XFER_BITS-1:0] tx;
  logic [BIT_CNT_W-1:0] bit_cnt;
  logic [7:0]           rx;
  logic                 tick;
  logic                 last_period;
  logic                 rise_en;
  logic [3:0]           bit_idx;

  logic csn_d;
  logic sclk_d;
  logic sdi_d;
  logic done_d;
  logic busy_d;

  spi_tick_gen #(
    .DIV (CLK_DIV)
  ) u_tick_gen (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (state == ST_IDLE),
    .tick  (tick)
  );

  // bit_cnt counts completed rising edges; 16 means the last high half-period is running.
  assign last_period = (bit_cnt == 5'd16);
  assign rise_en     = (state == ST_XFER) && tick && !SPI_CLK;
  assign bit_idx     = 4'd15 - bit_cnt[3:0];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_d;
    end
  end

  always_comb begin
    state_d = state;
    case (state)
      ST_IDLE:  if (start) state_d = ST_SETUP;
      ST_SETUP: if (tick) state_d = ST_XFER;
      ST_XFER:  if (tick && SPI_CLK && last_period) state_d = ST_HOLD;
      ST_HOLD:  if (tick) state_d = ST_GAP;
      ST_GAP:   if (tick) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Next values for the pin flops; the first falling edge coincides with leaving SETUP.
  always_comb begin
    csn_d  = SPI_CSN;
    sclk_d = SPI_CLK;
    sdi_d  = SPI_SDI;
    done_d = 1'b0;
    busy_d = (state_d != ST_IDLE);
    case (state)
      ST_IDLE: begin
        csn_d  = !start;
        sclk_d = 1'b1;
        sdi_d  = 1'b1;
      end
      ST_SETUP: begin
        if (tick) begin
          sclk_d = 1'b0;
          sdi_d  = tx[XFER_BITS-1];
        end
      end
      ST_XFER: begin
        if (tick) begin
          if (!SPI_CLK) begin
            sclk_d = 1'b1;
          end else if (!last_period) begin
            sclk_d = 1'b0;
            sdi_d  = tx[bit_idx];
          end
        end
      end
      ST_HOLD: begin
        if (tick) begin
          csn_d  = 1'b1;
          sdi_d  = 1'b1;
          done_d = 1'b1;
        end
      end
      ST_GAP: begin
        csn_d = 1'b1;
      end
      default: begin
        csn_d  = 1'b1;
        sclk_d = 1'b1;
        sdi_d  = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      SPI_CSN <= 1'b1;
      SPI_CLK <= 1'b1;
      SPI_SDI <= 1'b1;
      busy    <= 1'b0;
      done    <= 1'b0;
      rdata   <= 8'h00;
      tx      <= '0;
      bit_cnt <= '0;
      rx      <= 8'h00;
    end else begin
      SPI_CSN <= csn_d;
      SPI_CLK <= sclk_d;
      SPI_SDI <= sdi_d;
      busy    <= busy_d;
      done    <= done_d;
      if (state == ST_IDLE) begin
        bit_cnt <= '0;
        if (start) tx <= make_frame(rw, addr, wdata);
      end else if (rise_en) begin
        bit_cnt <= bit_cnt + 5'd1;
        // Only the data-phase samples (rising edges 8..15) are kept.
        if (bit_cnt[3]) rx <= {rx[6:0], SPI_SDO};
      end
      if (done_d && tx[XFER_BITS-1]) rdata <= rx;
    end
  end

endmodule
